mtimer: RTL and testbench

//  Machine-level timer/software-interrupt source (RISC-V mtime/mtimecmp/msip) for the pipelined RV32I core.

---
 rtl/mtimer_pkg.sv | 44 ++++
 rtl/mtimer_tick.sv | 28 ++
 rtl/mtimer.sv | 120 ++++++++++++
 tb/tb_mtimer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mtimer_pkg.sv
// Shared definitions for the machine timer: bus widths, register window offsets
// and the byte-strobe merge helper.
package mtimer_pkg;

  localparam int unsigned BUS_AW = 32;
  localparam int unsigned BUS_DW = 32;
  localparam int unsigned BUS_SW = BUS_DW / 8;
  localparam int unsigned OFS_W  = 6;

  localparam logic [BUS_AW-1:0] MTIMER_BASE = 32'h0200_0000;

  localparam logic [OFS_W-1:0] MSIP_OFS        = 6'h00;
  localparam logic [OFS_W-1:0] MTIMECMP_LO_OFS = 6'h08;
  localparam logic [OFS_W-1:0] MTIMECMP_HI_OFS = 6'h0C;
  localparam logic [OFS_W-1:0] MTIME_LO_OFS    = 6'h10;
  localparam logic [OFS_W-1:0] MTIME_HI_OFS    = 6'h14;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } bus_state_e;

  // Decoded access as seen inside the register window
  typedef struct packed {
    logic              we;
    logic [OFS_W-1:0]  ofs;
    logic [BUS_DW-1:0] wdata;
    logic [BUS_SW-1:0] wstrb;
  } mt_req_t;

  function automatic logic [BUS_DW-1:0] apply_wstrb(
    input logic [BUS_DW-1:0] old_val,
    input logic [BUS_DW-1:0] wdata,
    input logic [BUS_SW-1:0] wstrb
  );
    logic [BUS_DW-1:0] res;
    res = old_val;
    for (int b = 0; b < int'(BUS_SW); b++) begin
      if (wstrb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mtimer_tick.sv
// Prescaler for mtime: counts 0..TICK_DIV-1 and pulses tick for one cycle on wrap.
module mtimer_tick #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned      CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             wrap_c;

  assign wrap_c = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else begin
      cnt_q <= wrap_c ? '0 : cnt_q + CNT_W'(1);
      tick  <= wrap_c;
    end
  end

endmodule

// File: rtl/mtimer.sv
// Machine timer / software interrupt peripheral (mtime, mtimecmp, msip) on the
// MEM-stage data bus, with a two-state request/ready handshake.
module mtimer
  import mtimer_pkg::*;
#(
  parameter logic [BUS_AW-1:0] BASE_ADDR = MTIMER_BASE,
  parameter int unsigned       TICK_DIV  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bus_req,
  input  logic              bus_we,
  input  logic [BUS_AW-1:0] bus_addr,
  input  logic [BUS_DW-1:0] bus_wdata,
  input  logic [BUS_SW-1:0] bus_wstrb,
  output logic [BUS_DW-1:0] bus_rdata,
  output logic              bus_ready,
  output logic              timer_irq,
  output logic              soft_irq
);

  bus_state_e        state_q, state_d;
  logic [63:0]       mtime_q, mtime_d;
  logic [63:0]       mtimecmp_q, mtimecmp_d;
  logic              msip_q, msip_d;
  logic              ready_d;
  logic [BUS_DW-1:0] rdata_d;

  logic              tick;
  logic              hit_c;
  mt_req_t           req_c;
  logic [BUS_DW-1:0] rd_mux_c;
  logic [BUS_DW-1:0] wr_word_c;
  logic              addr_unused;

  mtimer_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign hit_c       = (bus_addr[BUS_AW-1:OFS_W] == BASE_ADDR[BUS_AW-1:OFS_W]);
  assign addr_unused = ^bus_addr[1:0];
  assign req_c       = '{we: bus_we, ofs: {bus_addr[OFS_W-1:2], 2'b00},
                         wdata: bus_wdata, wstrb: bus_wstrb};

  // Current register contents at the addressed offset; unmapped offsets read 0
  always_comb begin
    rd_mux_c = '0;
    case (req_c.ofs)
      MSIP_OFS:        rd_mux_c = {31'd0, msip_q};
      MTIMECMP_LO_OFS: rd_mux_c = mtimecmp_q[31:0];
      MTIMECMP_HI_OFS: rd_mux_c = mtimecmp_q[63:32];
      MTIME_LO_OFS:    rd_mux_c = mtime_q[31:0];
      MTIME_HI_OFS:    rd_mux_c = mtime_q[63:32];
      default:         rd_mux_c = '0;
    endcase
  end

  assign wr_word_c = apply_wstrb(rd_mux_c, req_c.wdata, req_c.wstrb);

  // Handshake FSM and register update; a software write to one mtime half
  // overrides the tick and leaves the other half untouched that cycle
  always_comb begin
    state_d    = state_q;
    ready_d    = 1'b0;
    rdata_d    = bus_rdata;
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;

    case (state_q)
      ST_IDLE: begin
        if (bus_req && hit_c) begin
          state_d = ST_ACK;
          ready_d = 1'b1;
          if (req_c.we) begin
            case (req_c.ofs)
              MSIP_OFS:        msip_d             = wr_word_c[0];
              MTIMECMP_LO_OFS: mtimecmp_d[31:0]   = wr_word_c;
              MTIMECMP_HI_OFS: mtimecmp_d[63:32]  = wr_word_c;
              MTIME_LO_OFS:    mtime_d            = {mtime_q[63:32], wr_word_c};
              MTIME_HI_OFS:    mtime_d            = {wr_word_c, mtime_q[31:0]};
              default:         ;
            endcase
          end else begin
            rdata_d = rd_mux_c;
          end
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bus_ready  <= 1'b0;
      bus_rdata  <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      msip_q     <= 1'b0;
      timer_irq  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bus_ready  <= ready_d;
      bus_rdata  <= rdata_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      timer_irq  <= (mtime_q >= mtimecmp_q);
    end
  end

  assign soft_irq = msip_q;

endmodule

// File: tb/tb_mtimer.sv
// Directed bench for mtimer: one DUT with TICK_DIV=1, one with TICK_DIV=4.
module tb_mtimer;

  localparam logic [31:0] BASE = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bus_req, bus_req4, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_rdata, bus_rdata4;
  logic        bus_ready, bus_ready4;
  logic        timer_irq, soft_irq, timer_irq4, soft_irq4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mtimer #(.BASE_ADDR(BASE), .TICK_DIV(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_rdata(bus_rdata), .bus_ready(bus_ready),
    .timer_irq(timer_irq), .soft_irq(soft_irq)
  );

  mtimer #(.BASE_ADDR(BASE), .TICK_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus_req(bus_req4), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_rdata(bus_rdata4), .bus_ready(bus_ready4),
    .timer_irq(timer_irq4), .soft_irq(soft_irq4)
  );

  // One bus access, launched at a falling edge; ok=0 if no ready within 6 cycles
  task automatic access(input bit sel4, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        output logic [31:0] rdata, output bit ok);
    @(negedge clk);
    bus_we    = we;
    bus_addr  = addr;
    bus_wdata = wdata;
    bus_wstrb = strb;
    if (sel4) bus_req4 = 1'b1; else bus_req = 1'b1;
    ok    = 1'b0;
    rdata = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (sel4 ? bus_ready4 : bus_ready) begin
        ok    = 1'b1;
        rdata = sel4 ? bus_rdata4 : bus_rdata;
        break;
      end
    end
    bus_req  = 1'b0;
    bus_req4 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus_req = 1'b0; bus_req4 = 1'b0; bus_we = 1'b0;
    bus_addr = '0; bus_wdata = '0; bus_wstrb = '0;
    repeat (3) @(negedge clk);
    total++; if (bus_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", bus_ready); end
    total++; if (bus_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", bus_rdata); end
    total++; if (timer_irq !== 1'b0) begin bad++; $display("FAIL reset_timer_irq got=%b exp=0", timer_irq); end
    total++; if (soft_irq !== 1'b0) begin bad++; $display("FAIL reset_soft_irq got=%b exp=0", soft_irq); end
    rst_n = 1'b1;
  endtask

  task automatic test_mtime_count();
    logic [31:0] rd; bit ok;
    repeat (10) @(negedge clk);
    access(1'b0, 1'b0, BASE + 32'h10, '0, 4'hF, rd, ok);
    total++; if (!ok) begin bad++; $display("FAIL count_ready got=0 exp=1"); end
    total++; if (rd < 32'd9 || rd > 32'd11) begin bad++; $display("FAIL count_mtime got=%h exp=0000000a+/-1", rd); end
    @(negedge clk);
    total++; if (bus_ready !== 1'b0) begin bad++; $display("FAIL count_single_pulse got=%b exp=0", bus_ready); end
    total++; if (timer_irq !== 1'b0) begin bad++; $display("FAIL count_irq got=%b exp=0", timer_irq); end
  endtask

  task automatic test_timer_irq();
    logic [31:0] rd; bit ok;
    access(1'b0, 1'b1, BASE + 32'h0C, 32'h0, 4'hF, rd, ok);
    access(1'b0, 1'b1, BASE + 32'h08, 32'h20, 4'hF, rd, ok);
    access(1'b0, 1'b1, BASE + 32'h10, 32'h10, 4'hF, rd, ok);
    // mtime is 0x10 after the write edge; reaches 0x20 sixteen edges later
    repeat (16) @(negedge clk);
    total++; if (timer_irq !== 1'b0) begin bad++; $display("FAIL irq_before got=%b exp=0", timer_irq); end
    @(negedge clk);
    total++; if (timer_irq !== 1'b1) begin bad++; $display("FAIL irq_rise got=%b exp=1", timer_irq); end
    access(1'b0, 1'b0, BASE + 32'h08, '0, 4'hF, rd, ok);
    total++; if (rd !== 32'h20) begin bad++; $display("FAIL cmp_lo_read got=%h exp=00000020", rd); end
    total++; if (timer_irq !== 1'b1) begin bad++; $display("FAIL irq_kept_by_read got=%b exp=1", timer_irq); end
    access(1'b0, 1'b1, BASE + 32'h08, 32'hFFFF_FFFF, 4'hF, rd, ok);
    total++; if (timer_irq !== 1'b1) begin bad++; $display("FAIL irq_lag got=%b exp=1", timer_irq); end
    @(negedge clk);
    total++; if (timer_irq !== 1'b0) begin bad++; $display("FAIL irq_fall got=%b exp=0", timer_irq); end
  endtask

  task automatic test_carry();
    logic [31:0] rd; bit ok;
    access(1'b0, 1'b1, BASE + 32'h14, 32'h0, 4'hF, rd, ok);
    access(1'b0, 1'b1, BASE + 32'h10, 32'hFFFF_FFFF, 4'hF, rd, ok);
    access(1'b0, 1'b0, BASE + 32'h10, '0, 4'hF, rd, ok);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL carry_lo got=%h exp=00000000", rd); end
    access(1'b0, 1'b0, BASE + 32'h14, '0, 4'hF, rd, ok);
    total++; if (rd !== 32'h1) begin bad++; $display("FAIL carry_hi got=%h exp=00000001", rd); end
    access(1'b0, 1'b1, BASE + 32'h14, 32'hFFFF_FFFF, 4'hF, rd, ok);
    access(1'b0, 1'b1, BASE + 32'h10, 32'hFFFF_FFFF, 4'hF, rd, ok);
    access(1'b0, 1'b0, BASE + 32'h10, '0, 4'hF, rd, ok);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL wrap_lo got=%h exp=00000000", rd); end
    access(1'b0, 1'b0, BASE + 32'h14, '0, 4'hF, rd, ok);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL wrap_hi got=%h exp=00000000", rd); end
  endtask

  task automatic test_msip();
    logic [31:0] rd; bit ok;
    access(1'b0, 1'b1, BASE + 32'h00, 32'hFFFF_FFFF, 4'hF, rd, ok);
    total++; if (soft_irq !== 1'b1) begin bad++; $display("FAIL msip_set got=%b exp=1", soft_irq); end
    access(1'b0, 1'b0, BASE + 32'h00, '0, 4'hF, rd, ok);
    total++; if (rd !== 32'h1) begin bad++; $display("FAIL msip_read got=%h exp=00000001", rd); end
    access(1'b0, 1'b1, BASE + 32'h00, 32'h0, 4'h0, rd, ok);
    total++; if (soft_irq !== 1'b1) begin bad++; $display("FAIL msip_nostrb got=%b exp=1", soft_irq); end
    access(1'b0, 1'b1, BASE + 32'h00, 32'h0, 4'hF, rd, ok);
    total++; if (soft_irq !== 1'b0) begin bad++; $display("FAIL msip_clear got=%b exp=0", soft_irq); end
  endtask

  task automatic test_strobe_decode();
    logic [31:0] rd; bit ok;
    access(1'b0, 1'b1, BASE + 32'h08, 32'hFFFF_FFFF, 4'hF, rd, ok);
    access(1'b0, 1'b1, BASE + 32'h08, 32'h0000_AB00, 4'b0010, rd, ok);
    access(1'b0, 1'b0, BASE + 32'h08, '0, 4'hF, rd, ok);
    total++; if (rd !== 32'hFFFF_ABFF) begin bad++; $display("FAIL strobe_cmp_lo got=%h exp=ffffabff", rd); end
    access(1'b0, 1'b0, BASE + 32'h20, '0, 4'hF, rd, ok);
    total++; if (!ok) begin bad++; $display("FAIL unmapped_ready got=0 exp=1"); end
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL unmapped_rdata got=%h exp=00000000", rd); end
    access(1'b0, 1'b0, 32'h0300_0010, '0, 4'hF, rd, ok);
    total++; if (ok) begin bad++; $display("FAIL nonhit_ready got=1 exp=0"); end
  endtask

  task automatic test_back_to_back();
    int pulses;
    bit prev;
    pulses = 0;
    prev   = 1'b0;
    @(negedge clk);
    bus_we = 1'b0; bus_addr = BASE; bus_wstrb = 4'hF; bus_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus_ready) pulses++;
      total++; if (prev && bus_ready) begin bad++; $display("FAIL b2b_adjacent got=1 exp=0 cycle=%0d", i); end
      prev = bus_ready;
    end
    bus_req = 1'b0;
    total++; if (pulses != 4) begin bad++; $display("FAIL b2b_pulses got=%0d exp=4", pulses); end
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] rd, t0, t1; bit ok;
    @(negedge clk);
    bus_we = 1'b1; bus_addr = BASE; bus_wdata = 32'h1; bus_wstrb = 4'hF; bus_req = 1'b1;
    @(posedge clk);
    #2;
    total++; if (bus_ready !== 1'b1) begin bad++; $display("FAIL mid_ack_ready got=%b exp=1", bus_ready); end
    total++; if (soft_irq !== 1'b1) begin bad++; $display("FAIL mid_ack_msip got=%b exp=1", soft_irq); end
    rst_n = 1'b0;
    #1;
    total++; if (bus_ready !== 1'b0) begin bad++; $display("FAIL rst_async_ready got=%b exp=0", bus_ready); end
    total++; if (soft_irq !== 1'b0) begin bad++; $display("FAIL rst_async_msip got=%b exp=0", soft_irq); end
    bus_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    access(1'b0, 1'b0, BASE + 32'h10, '0, 4'hF, rd, ok);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL rst_mtime got=%h exp=00000000", rd); end
    access(1'b0, 1'b0, BASE + 32'h08, '0, 4'hF, rd, ok);
    total++; if (rd !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rst_cmp_lo got=%h exp=ffffffff", rd); end
    access(1'b0, 1'b0, BASE + 32'h0C, '0, 4'hF, rd, ok);
    total++; if (rd !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rst_cmp_hi got=%h exp=ffffffff", rd); end
    // TICK_DIV=4: capture edges 8 apart see exactly two ticks, 4 apart see one
    access(1'b1, 1'b0, BASE + 32'h10, '0, 4'hF, t0, ok);
    total++; if (!ok) begin bad++; $display("FAIL div4_ready got=0 exp=1"); end
    repeat (6) @(negedge clk);
    access(1'b1, 1'b0, BASE + 32'h10, '0, 4'hF, t1, ok);
    total++; if (t1 - t0 !== 32'd2) begin bad++; $display("FAIL div4_step8 got=%0d exp=2", t1 - t0); end
    repeat (2) @(negedge clk);
    access(1'b1, 1'b0, BASE + 32'h10, '0, 4'hF, t0, ok);
    total++; if (t0 - t1 !== 32'd1) begin bad++; $display("FAIL div4_step4 got=%0d exp=1", t0 - t1); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_mtime_count();
    test_timer_irq();
    test_carry();
    test_msip();
    test_strobe_decode();
    test_back_to_back();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
